// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and the
// digit-counter width helper.
package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

  // Counter width for k digits; at least one bit so K == 1 still has a counter.
  function automatic int unsigned cnt_width(input int unsigned k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/digit_sub.sv
// Combinational DIGIT-bit subtractor: x - y - bi as a borrow-ripple chain of
// full-subtractor cells. d is the digit difference, bo the borrow-out.
module digit_sub #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT:0] br;

  assign br[0] = bi;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign d[i]    = x[i] ^ y[i] ^ br[i];
    // Borrow when x < y, or when x == y and a borrow ripples in.
    assign br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
  end

  assign bo = br[DIGIT];

endmodule

// File: rtl/serial_sub.sv
// Multi-cycle subtractor: df = a - b - bin over WIDTH bits, DIGIT bits per
// clock, LSB digit first. Start/done handshake; outputs are registered.
// Optional build macro SERIAL_SUB_SAT_EN: clamp df to 0 on final borrow.
// DIGIT must divide WIDTH.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] df,
  output logic             bw
);

  localparam int unsigned K     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = cnt_width(K);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] df_q, df_d;
  logic             bw_q, bw_d;

  logic [DIGIT-1:0] dig_d;
  logic             dig_bo;
  logic [WIDTH-1:0] res_shift;
  logic             accept;
  logic             last;

  // Operands are shifted right each digit, so the current digit is always
  // the low DIGIT bits and the result fills in from the top.
  digit_sub #(
    .DIGIT(DIGIT)
  ) u_digit_sub (
    .x (a_q[DIGIT-1:0]),
    .y (b_q[DIGIT-1:0]),
    .bi(borrow_q),
    .d (dig_d),
    .bo(dig_bo)
  );

  assign res_shift = (res_q >> DIGIT) | (WIDTH'(dig_d) << (WIDTH - DIGIT));
  assign accept    = start && (state_q == StIdle || state_q == StDone);
  assign last      = (cnt_q == LAST);

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      df_q     <= '0;
      bw_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      df_q     <= df_d;
      bw_q     <= bw_d;
    end
  end

  // Next-state logic: DONE accepts a new start just like IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: state_d = start ? StRun : StIdle;
      StRun:          if (last) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // Datapath next-state: latch on accept, one digit per RUN cycle, publish on the last digit.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    df_d     = df_q;
    bw_d     = bw_q;
    if (accept) begin
      a_d      = a;
      b_d      = b;
      borrow_d = bin;
      cnt_d    = '0;
    end else if (state_q == StRun) begin
      a_d      = a_q >> DIGIT;
      b_d      = b_q >> DIGIT;
      borrow_d = dig_bo;
      cnt_d    = cnt_q + 1'b1;
      res_d    = res_shift;
      if (last) begin
        bw_d = dig_bo;
`ifdef SERIAL_SUB_SAT_EN
        df_d = dig_bo ? '0 : res_shift;
`else
        df_d = res_shift;
`endif
      end
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  assign df = df_q;
  assign bw = bw_q;

endmodule

// File: doc/serial_sub.md
# serial_sub

Parametrised multi-cycle subtractor computing `a - b - bin` over `WIDTH` bits, `DIGIT` bits per clock, LSB digit first, with the borrow carried in a register between digits. It generalises the single-bit half/full subtractor cells into a start/done handshaked datapath unit. Arithmetic blocks that trade latency for area use it in place of a flat `WIDTH`-bit ripple subtractor.

## Interface
**Parameters**
- `WIDTH`, 8: operand and result width in bits. Must be ≥ 1.
- `DIGIT`, 1: bits processed per cycle. Must divide `WIDTH`. `K = WIDTH/DIGIT` is the digit count.

**Ports**
- `clk` input 1: the single clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request. Sampled on a rising edge.
- `a` input `WIDTH`: minuend, unsigned. Sampled with an accepted `start`.
- `b` input `WIDTH`: subtrahend, unsigned. Sampled with an accepted `start`.
- `bin` input 1: borrow-in. Sampled with an accepted `start`.
- `busy` output 1: high while digits are being computed.
- `done` output 1: one-cycle pulse when `df`/`bw` are updated.
- `df` output `WIDTH`: difference, `(a - b - bin) mod 2^WIDTH`.
- `bw` output 1: final borrow-out. It is 1 exactly when `a < b + bin`.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:** `busy=0`, `done=0`.
  - `start=1` → latch `a`, `b`, `bin` into internal registers, clear the digit counter, go to RUN.
- **RUN:** `busy=1`. Each edge does the following, then increments the counter:
  - Compute digit `i` (bits `i*DIGIT +: DIGIT`) as `a_i - b_i - borrow_reg`.
  - Write the digit into the internal result register.
  - Update `borrow_reg`.
- **RUN exit:** the edge that processes digit `K-1` does all of the following:
  - Transfers the internal result to `df`.
  - Transfers the final borrow to `bw`.
  - Moves to DONE.
- **DONE:** `done=1` for exactly one cycle.
  - `start=1` in DONE is accepted exactly as in IDLE and goes to RUN.
  - Otherwise go to IDLE.
- **Start while busy:** `start` while in RUN is ignored. Operands are not re-latched and the operation completes unchanged.
- **Output hold:** `df` and `bw` change only at the RUN→DONE transition. They hold the last result through IDLE and through subsequent RUN phases.
- **Per-digit arithmetic:** the digit result is `DIGIT+1` bits wide. Its MSB is the borrow-out and the lower `DIGIT` bits are the digit difference.
  - Carry-less; no sign interpretation.
- **Boundary, `WIDTH == DIGIT`:** `K = 1`. RUN lasts one cycle.
- **Boundary, reset mid-operation:** abandons the operation. Operand, counter and borrow registers are cleared.
- **Reset values:** state=IDLE, `busy=0`, `done=0`, `df=0`, `bw=0`.

## Timing
- `start` sampled at edge 0 → `busy` high cycles 1..K → `done` high in cycle K+1.
  - `df`/`bw` are valid from cycle K+1 until the next completion.
- Latency is K+1 edges from accepted `start` to `done`:
  - `WIDTH=8, DIGIT=1` → `done` in cycle 9.
  - `WIDTH=8, DIGIT=4` → `done` in cycle 3.
- Back-to-back throughput: one result per K+1 cycles, with `start` held or re-asserted in the DONE cycle.
- `rst` has priority over `start` on the same edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- **`SERIAL_SUB_SAT_EN`:**
  - **Defined:** saturating mode. When the final borrow is 1, `df` is loaded with 0 instead of the wrapped value. `bw` still reports 1.
  - **Undefined:** `df` is the modular result.
  - Latency is identical in both builds.

## Structure
- **Package `serial_sub_pkg`:**
  - State encoding constants `ST_IDLE=2'd0`, `ST_RUN=2'd1`, `ST_DONE=2'd2`.
  - Counter-width helper `CNT_W = clog2(K)`, minimum 1.
- **Sub-module `digit_sub`:** combinational, parameter `DIGIT`.
  - Inputs `x[DIGIT]`, `y[DIGIT]`, `bi`; outputs `d[DIGIT]`, `bo`.
  - Built as a borrow-ripple chain of full-subtractor cells.
  - `serial_sub` instantiates it once.
- **Top:** `serial_sub` holds the FSM, counter, operand/borrow registers and output registers.

## Test plan
- **Basic subtract:** `WIDTH=8, DIGIT=1`, start with `a=200, b=55, bin=0` → `busy` cycles 1–8, `done` in cycle 9, `df=145`, `bw=0`.
- **Underflow:** `a=10, b=20, bin=0` → `df=246`, `bw=1`. With `SERIAL_SUB_SAT_EN` defined → `df=0`, `bw=1`.
- **Borrow-in wrap:** `a=0, b=0, bin=1` → `df=255`, `bw=1`. Then `a=255, b=255, bin=0` → `df=0`, `bw=0`.
- **Start while busy:** start `a=100, b=1`, then in cycle 4 pulse `start` with `a=7, b=3` → result `df=99`, single `done` in cycle 9, no second operation.
- **Reset mid-operation:** start `a=50, b=20`, assert `rst` in cycle 5 → next cycle all outputs 0, IDLE, no `done`. Then a new start `a=9, b=4` → `df=5` after 9 cycles.
- **Wide digits, back-to-back:** `WIDTH=8, DIGIT=4`, `a=0x3C, b=0x0F` → `done` in cycle 3, `df=0x2D`. Start held in the DONE cycle with `a=0x01, b=0x02` → `done` three cycles later, `df=0xFF`, `bw=1`.
